mult_arbiter: RTL

//  Shares one shift-add multiplier (8-bit M/Q load, start, ready, 16-bit AQ readback)

---
 rtl/mult_arbiter.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/mult_arbiter.sv
// Round-robin arbiter that shares one shift-add multiplier among NREQ requesters:
// load M, load Q, start, wait for ready, read AQ low/high, then a one-cycle ack.
module mult_arbiter #(
    parameter int unsigned W       = 8,
    parameter int unsigned NREQ    = 2,
    parameter int unsigned TIMEOUT = 64,
    parameter int unsigned BUSYWIN = 4
) (
    input  logic              clk,
    input  logic              n_reset,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*W-1:0] opa,
    input  logic [NREQ*W-1:0] opb,
    output logic [NREQ-1:0]   ack,
    output logic              err,
    output logic [2*W-1:0]    product,
    output logic [1:0]        mul_func,
    output logic              mul_oe,
    output logic [W-1:0]      mul_wdata,
    output logic              mul_wen,
    input  logic [W-1:0]      mul_rdata,
    output logic              mul_start,
    input  logic              mul_ready
);

    localparam int unsigned PW   = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned CMAX = (TIMEOUT > BUSYWIN) ? TIMEOUT : BUSYWIN;
    localparam int unsigned CW   = $clog2(CMAX + 1);

    localparam logic [1:0] FUNC_LD_M  = 2'b00;
    localparam logic [1:0] FUNC_LD_Q  = 2'b01;
    localparam logic [1:0] FUNC_RD_LO = 2'b10;
    localparam logic [1:0] FUNC_RD_HI = 2'b11;

    typedef enum logic [3:0] {
        S_IDLE,
        S_LOAD_M,
        S_LOAD_Q,
        S_START,
        S_WAIT,
        S_READ_LO,
        S_READ_HI,
        S_RESP,
        S_FAIL
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d, cnt_inc;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [PW-1:0]   gnt_q, gnt_d;
    logic [W-1:0]    opb_q, opb_d;
    logic [NREQ-1:0] ack_q, ack_d;
    logic            err_q, err_d;
    logic [2*W-1:0]  product_q, product_d;
    logic [1:0]      func_q, func_d;
    logic            oe_q, oe_d;
    logic [W-1:0]    wdata_q, wdata_d;
    logic            wen_q, wen_d;
    logic            start_q, start_d;

    logic            found;
    logic [PW-1:0]   cand;
    logic [PW-1:0]   pick;
    logic [W-1:0]    opa_sel;

    // State and registered outputs
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            ptr_q     <= PW'(NREQ - 1);
            gnt_q     <= '0;
            opb_q     <= '0;
            ack_q     <= '0;
            err_q     <= 1'b0;
            product_q <= '0;
            func_q    <= FUNC_RD_LO;
            oe_q      <= 1'b0;
            wdata_q   <= '0;
            wen_q     <= 1'b0;
            start_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ptr_q     <= ptr_d;
            gnt_q     <= gnt_d;
            opb_q     <= opb_d;
            ack_q     <= ack_d;
            err_q     <= err_d;
            product_q <= product_d;
            func_q    <= func_d;
            oe_q      <= oe_d;
            wdata_q   <= wdata_d;
            wen_q     <= wen_d;
            start_q   <= start_d;
        end
    end

    // Next state, then outputs decoded from the state being entered
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ptr_d     = ptr_q;
        gnt_d     = gnt_q;
        opb_d     = opb_q;
        product_d = product_q;
        ack_d     = '0;
        err_d     = 1'b0;
        func_d    = FUNC_RD_LO;
        oe_d      = 1'b0;
        wdata_d   = '0;
        wen_d     = 1'b0;
        start_d   = 1'b0;
        found     = 1'b0;
        cand      = '0;
        pick      = ptr_q;
        cnt_inc   = (cnt_q == CW'(CMAX)) ? cnt_q : cnt_q + CW'(1);

        // first requester after the last winner, wrapping
        for (int unsigned i = 1; i <= NREQ; i++) begin
            cand = PW'((32'(ptr_q) + i) % NREQ);
            if (!found && req[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
        opa_sel = opa[32'(pick)*W +: W];

        case (state_q)
            S_IDLE: begin
                if (mul_ready && found) begin
                    ptr_d   = pick;
                    gnt_d   = pick;
                    opb_d   = opb[32'(pick)*W +: W];
                    state_d = S_LOAD_M;
                end
            end
            S_LOAD_M: state_d = S_LOAD_Q;
            S_LOAD_Q: begin
                cnt_d   = '0;
                state_d = S_START;
            end
            S_START: begin
                if (!mul_ready) begin
                    cnt_d   = '0;
                    state_d = S_WAIT;
                end else if (cnt_q >= CW'(BUSYWIN - 1)) begin
                    state_d = S_FAIL;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            S_WAIT: begin
                if (mul_ready) begin
                    state_d = S_READ_LO;
                end else if (cnt_q >= CW'(TIMEOUT - 1)) begin
                    state_d = S_FAIL;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            S_READ_LO: begin
                product_d[W-1:0] = mul_rdata;
                state_d          = S_READ_HI;
            end
            S_READ_HI: begin
                product_d[2*W-1:W] = mul_rdata;
                state_d            = S_RESP;
            end
            S_RESP:  state_d = S_IDLE;
            S_FAIL:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        case (state_d)
            S_LOAD_M: begin
                func_d  = FUNC_LD_M;
                wen_d   = 1'b1;
                wdata_d = opa_sel;
            end
            S_LOAD_Q: begin
                func_d  = FUNC_LD_Q;
                wen_d   = 1'b1;
                wdata_d = opb_q;
            end
            S_START:   start_d = 1'b1;
            S_READ_LO: oe_d    = 1'b1;
            S_READ_HI: begin
                func_d = FUNC_RD_HI;
                oe_d   = 1'b1;
            end
            S_RESP: ack_d[gnt_q] = 1'b1;
            S_FAIL: begin
                ack_d[gnt_q] = 1'b1;
                err_d        = 1'b1;
                product_d    = '0;
            end
            default: ;
        endcase
    end

    assign ack       = ack_q;
    assign err       = err_q;
    assign product   = product_q;
    assign mul_func  = func_q;
    assign mul_oe    = oe_q;
    assign mul_wdata = wdata_q;
    assign mul_wen   = wen_q;
    assign mul_start = start_q;

endmodule
